// File: rtl/fpmult_pipe_if.sv
// fpmult_pipe_if: operand/result bundle for the pipelined FP multiplier.
//
// Signals (W = 1+EXP_W+MAN_W):
//   ce        pipeline enable; when low every stage of the consumer holds
//   in_valid  dataa/datab carry an operand pair (sampled only when ce=1)
//   dataa     operand A {sign, exp, frac}
//   datab     operand B {sign, exp, frac}
//   out_valid result/flags hold a product
//   result    product word
//   flags     {invalid, overflow, underflow, inexact}, qualified by out_valid
//
// Handshake: there is no ready. A pair is accepted on every rising edge where
// ce=1 and in_valid=1. The product emerges exactly four enabled edges later
// with out_valid=1. Stalling is done only through ce, which freezes every stage.
// The master modport drives operands and ce. The slave modport is the multiplier.
interface fpmult_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) ();
    localparam int W = 1 + EXP_W + MAN_W;

    logic         ce;
    logic         in_valid;
    logic [W-1:0] dataa;
    logic [W-1:0] datab;
    logic         out_valid;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output ce, in_valid, dataa, datab,
        input  out_valid, result, flags
    );

    modport slave (
        input  ce, in_valid, dataa, datab,
        output out_valid, result, flags
    );
endinterface

// File: rtl/fpmult_pipe.sv
// fpmult_pipe: four-stage pipelined floating-point multiplier.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high; clears all valid bits and the outputs
//   bus    fpmult_pipe_if slave (ce, in_valid, dataa, datab, out_valid,
//          result, flags)
//
// Stages: S1 unpack, S2 mantissa multiply and exponent add, S3 normalise and
// round, S4 renormalise, exception priority and output register.
// Denormal inputs are flushed to zero. Underflowing products are flushed to
// signed zero. The valid bit of each stage advances whenever ce=1. The data
// registers of a stage load only when the stage feeding them is valid, so
// bubbles leave stale data behind them.
module fpmult_pipe #(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int ROUND_NE = 1
) (
    input logic          clk,
    input logic          reset,
    fpmult_pipe_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;   // signed exponent with headroom, never wraps

    localparam logic [EXP_W-1:0]        EMAX_F = '1;
    localparam logic signed [EW-1:0]    EMAX_S = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0]    BIAS   = EW'((1 << (EXP_W - 1)) - 1);

    // ---------------- operand classification ----------------
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic [2:0]       a_cls, b_cls;   // {nan, inf, zero}

    always_comb begin
        a_exp  = bus.dataa[W-2:MAN_W];
        b_exp  = bus.datab[W-2:MAN_W];
        a_frac = bus.dataa[MAN_W-1:0];
        b_frac = bus.datab[MAN_W-1:0];
        a_cls  = {(a_exp == EMAX_F) && (a_frac != '0),
                  (a_exp == EMAX_F) && (a_frac == '0),
                  (a_exp == '0)};
        b_cls  = {(b_exp == EMAX_F) && (b_frac != '0),
                  (b_exp == EMAX_F) && (b_frac == '0),
                  (b_exp == '0)};
    end

    // ---------------- S1: unpack ----------------
    logic             s1_valid, s1_sign;
    logic [EXP_W-1:0] s1_ea, s1_eb;
    logic [MAN_W:0]   s1_ma, s1_mb;
    logic [2:0]       s1_cls_a, s1_cls_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_ea    <= '0;
            s1_eb    <= '0;
            s1_ma    <= '0;
            s1_mb    <= '0;
            s1_cls_a <= '0;
            s1_cls_b <= '0;
        end else if (bus.ce) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign  <= bus.dataa[W-1] ^ bus.datab[W-1];
                s1_ea    <= a_exp;
                s1_eb    <= b_exp;
                s1_ma    <= {1'b1, a_frac};
                s1_mb    <= {1'b1, b_frac};
                s1_cls_a <= a_cls;
                s1_cls_b <= b_cls;
            end
        end
    end

    // ---------------- S2: multiply ----------------
    logic                 s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
    logic [PW-1:0]        s2_p;
    logic signed [EW-1:0] s2_e;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_nan   <= 1'b0;
            s2_inf   <= 1'b0;
            s2_zero  <= 1'b0;
            s2_p     <= '0;
            s2_e     <= '0;
        end else if (bus.ce) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign <= s1_sign;
                // inf x zero is invalid, same as a NaN operand
                s2_nan  <= s1_cls_a[2] | s1_cls_b[2]
                         | (s1_cls_a[1] & s1_cls_b[0])
                         | (s1_cls_b[1] & s1_cls_a[0]);
                s2_inf  <= s1_cls_a[1] | s1_cls_b[1];
                s2_zero <= s1_cls_a[0] | s1_cls_b[0];
                s2_p    <= PW'(s1_ma) * PW'(s1_mb);
                s2_e    <= EW'({2'b00, s1_ea}) + EW'({2'b00, s1_eb}) - BIAS;
            end
        end
    end

    // ---------------- S3: normalise and round ----------------
    logic             norm_hi, guard, sticky, round_up;
    logic [MAN_W-1:0] mant;

    always_comb begin
        norm_hi = s2_p[PW-1];
        if (norm_hi) begin
            mant   = s2_p[2*MAN_W:MAN_W+1];
            guard  = s2_p[MAN_W];
            sticky = |s2_p[MAN_W-1:0];
        end else begin
            mant   = s2_p[2*MAN_W-1:MAN_W];
            guard  = s2_p[MAN_W-1];
            sticky = |s2_p[MAN_W-2:0];
        end
        round_up = (ROUND_NE != 0) && guard && (sticky || mant[0]);
    end

    logic                 s3_valid, s3_sign, s3_nan, s3_inf, s3_zero, s3_inexact;
    logic [MAN_W:0]       s3_frac;   // extra top bit catches the rounding carry
    logic signed [EW-1:0] s3_e;

    always_ff @(posedge clk) begin
        if (reset) begin
            s3_valid   <= 1'b0;
            s3_sign    <= 1'b0;
            s3_nan     <= 1'b0;
            s3_inf     <= 1'b0;
            s3_zero    <= 1'b0;
            s3_inexact <= 1'b0;
            s3_frac    <= '0;
            s3_e       <= '0;
        end else if (bus.ce) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_sign    <= s2_sign;
                s3_nan     <= s2_nan;
                s3_inf     <= s2_inf;
                s3_zero    <= s2_zero;
                s3_inexact <= guard | sticky;
                s3_frac    <= {1'b0, mant} + (MAN_W+1)'(round_up);
                s3_e       <= s2_e + EW'(norm_hi);
            end
        end
    end

    // ---------------- S4: renormalise and exceptions ----------------
    logic                 carry;
    logic signed [EW-1:0] e_fin;
    logic [MAN_W-1:0]     frac_fin;
    logic [W-1:0]         res_n;
    logic [3:0]           flg_n;

    always_comb begin
        carry    = s3_frac[MAN_W];
        e_fin    = s3_e + EW'(carry);
        frac_fin = carry ? '0 : s3_frac[MAN_W-1:0];
        res_n    = '0;
        flg_n    = '0;
        if (s3_nan) begin
            res_n = {1'b0, EMAX_F, 1'b1, {(MAN_W-1){1'b0}}};
            flg_n = 4'b1000;
        end else if (s3_inf) begin
            res_n = {s3_sign, EMAX_F, {MAN_W{1'b0}}};
        end else if (s3_zero) begin
            res_n = {s3_sign, {(W-1){1'b0}}};
        end else if (e_fin >= EMAX_S) begin
            res_n = {s3_sign, EMAX_F, {MAN_W{1'b0}}};
            flg_n = 4'b0101;
        end else if (e_fin[EW-1] || (e_fin == '0)) begin
            res_n = {s3_sign, {(W-1){1'b0}}};
            flg_n = 4'b0011;
        end else begin
            res_n = {s3_sign, e_fin[EXP_W-1:0], frac_fin};
            flg_n = {3'b000, s3_inexact};
        end
    end

    logic         out_valid_q;
    logic [W-1:0] result_q;
    logic [3:0]   flags_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (bus.ce) begin
            out_valid_q <= s3_valid;
            if (s3_valid) begin
                result_q <= res_n;
                flags_q  <= flg_n;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_fpmult_pipe.sv
// tb_fpmult_pipe: checks fpmult_pipe in single precision (round-to-nearest-even
// and truncating) and half precision. It uses directed vector tables, latency
// sequences, a reset-in-flight sequence, and randomized streaming with random
// ce stalls. The streaming results are compared against an arithmetic
// reference model through an expected queue.
module tb_fpmult_pipe;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fpmult_pipe_if #(.EXP_W(8), .MAN_W(23)) if0 ();
    fpmult_pipe_if #(.EXP_W(8), .MAN_W(23)) if1 ();
    fpmult_pipe_if #(.EXP_W(5), .MAN_W(10)) if2 ();

    fpmult_pipe #(.EXP_W(8), .MAN_W(23), .ROUND_NE(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    fpmult_pipe #(.EXP_W(8), .MAN_W(23), .ROUND_NE(0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    fpmult_pipe #(.EXP_W(5), .MAN_W(10), .ROUND_NE(1)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    int tests  = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: single precision, round-to-nearest-even, computed with
    // integer arithmetic on the real mantissa values.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e, sh;
        logic s;
        bit az, bz, ai, bi, an, bn, up;
        longint unsigned ma, mb, p, q, rem, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        if (an || bn || (ai && bz) || (bi && az)) return {4'b1000, 32'h7FC00000};
        if (ai || bi) return {4'b0000, s, 8'hFF, 23'd0};
        if (az || bz) return {4'b0000, s, 31'd0};
        ma = 64'(a[22:0]) + (64'd1 << 23);
        mb = 64'(b[22:0]) + (64'd1 << 23);
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        up   = (rem > half) || ((rem == half) && ((q % 2) == 1));
        q    = q + 64'(up);
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0) return {4'b0011, s, 31'd0};
        return {3'b000, (rem != 0), s, e[7:0], q[22:0]};
    endfunction

    // ---------------- scoreboard for dut0 ----------------
    logic [35:0] exp_q[$];
    bit          sb_on = 1'b0;
    logic        mon_ce, mon_rst, held_v;
    logic [35:0] held, popped;

    always @(posedge clk) begin
        mon_ce  = if0.ce;
        mon_rst = reset;
        #1;
        if (sb_on && !mon_rst) begin
            if (!mon_ce) begin
                check("stall_hold_valid", if0.out_valid, held_v);
                check("stall_hold_data", {if0.flags, if0.result}, held);
            end else if (if0.out_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected no output", {if0.flags, if0.result});
                end else begin
                    popped = exp_q.pop_front();
                    check("stream", {if0.flags, if0.result}, popped);
                end
            end
        end
        held_v = if0.out_valid;
        held   = {if0.flags, if0.result};
    end

    task automatic drive0(input bit c, input bit v, input logic [31:0] a,
                          input logic [31:0] b, input logic [35:0] exp);
        @(negedge clk);
        if0.ce       = c;
        if0.in_valid = v;
        if0.dataa    = a;
        if0.datab    = b;
        if (sb_on && c && v && !reset) exp_q.push_back(exp);
    endtask

    task automatic drain0(input bit random_ce);
        for (int n = 0; n < 300 && exp_q.size() != 0; n++)
            drive0(random_ce ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 32'd0, 32'd0, 36'd0);
        repeat (2) drive0(1'b1, 1'b0, 32'd0, 32'd0, 36'd0);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic lat0(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [35:0] exp);
        @(negedge clk);
        if0.ce = 1'b1; if0.in_valid = 1'b1; if0.dataa = a; if0.datab = b;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) if0.in_valid = 1'b0;
            check({nm, "_valid"}, if0.out_valid, 64'(k == 4));
            if (k == 4) check({nm, "_data"}, {if0.flags, if0.result}, exp);
        end
    endtask

    task automatic lat1(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [35:0] exp);
        @(negedge clk);
        if1.ce = 1'b1; if1.in_valid = 1'b1; if1.dataa = a; if1.datab = b;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) if1.in_valid = 1'b0;
            check({nm, "_valid"}, if1.out_valid, 64'(k == 4));
            if (k == 4) check({nm, "_data"}, {if1.flags, if1.result}, exp);
        end
    endtask

    task automatic lat2(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic [19:0] exp);
        @(negedge clk);
        if2.ce = 1'b1; if2.in_valid = 1'b1; if2.dataa = a; if2.datab = b;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) if2.in_valid = 1'b0;
            check({nm, "_valid"}, if2.out_valid, 64'(k == 4));
            if (k == 4) check({nm, "_data"}, {if2.flags, if2.result}, exp);
        end
    endtask

    function automatic logic [31:0] rand_normal();
        logic [31:0] r;
        r        = $urandom;
        r[30:23] = 8'($urandom_range(64, 190));
        return r;
    endfunction

    function automatic logic [31:0] rand_any();
        logic [31:0] r;
        int sel;
        r   = $urandom;
        sel = $urandom_range(0, 7);
        if (sel == 0) r[30:23] = 8'h00;
        if (sel == 1) r[30:23] = 8'hFF;
        if (sel == 2) r[22:0]  = 23'd0;
        if (sel >= 3 && sel <= 5) r[30:23] = 8'($urandom_range(100, 150));
        return r;
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [35:0] exp;   // {flags, result}
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [31:0] ra, rb;
        bit c;
        int tries;

        tbl[0] = '{32'h40000000, 32'h40400000, {4'h0, 32'h40C00000}};
        tbl[1] = '{32'h3FC00000, 32'h3FC00000, {4'h0, 32'h40100000}};
        tbl[2] = '{32'h3F800001, 32'h3FC00000, {4'h1, 32'h3FC00002}};
        tbl[3] = '{32'h7F000000, 32'h7F000000, {4'h5, 32'h7F800000}};
        tbl[4] = '{32'h00800000, 32'h80800000, {4'h3, 32'h80000000}};
        tbl[5] = '{32'h7F800000, 32'h00000000, {4'h8, 32'h7FC00000}};
        tbl[6] = '{32'hFF800000, 32'h40000000, {4'h0, 32'hFF800000}};
        tbl[7] = '{32'h3F800001, 32'h3FFFFFFE, {4'h1, 32'h40000000}};
        tbl[8] = '{32'h7FC00000, 32'h3F800000, {4'h8, 32'h7FC00000}};
        tbl[9] = '{32'h00000001, 32'hC0000000, {4'h0, 32'h80000000}};

        // clock/reset: reset is held with ce=0 to show it does not need ce
        reset = 1'b1;
        if0.ce = 1'b0; if0.in_valid = 1'b0; if0.dataa = '0; if0.datab = '0;
        if1.ce = 1'b1; if1.in_valid = 1'b0; if1.dataa = '0; if1.datab = '0;
        if2.ce = 1'b1; if2.in_valid = 1'b0; if2.dataa = '0; if2.datab = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", if0.out_valid, 0);
        check("rst_result", if0.result, 0);
        check("rst_flags", if0.flags, 0);
        check("rst_h_result", {if2.out_valid, if2.flags, if2.result}, 0);
        reset = 1'b0;

        // basic latency
        lat0("lat_2x3", 32'h40000000, 32'h40400000, {4'h0, 32'h40C00000});

        // table-driven vectors, back to back
        sb_on = 1'b1;
        for (int i = 0; i < 10; i++) drive0(1'b1, 1'b1, tbl[i].a, tbl[i].b, tbl[i].exp);
        drain0(1'b0);

        // eight normal pairs streamed under random ce stalls
        for (int i = 0; i < 8; i++) begin
            ra = rand_normal();
            rb = rand_normal();
            c = 1'b0;
            tries = 0;
            while (!c) begin
                c = (tries > 20) ? 1'b1 : 1'($urandom_range(0, 1));
                drive0(c, 1'b1, ra, rb, ref_mul(ra, rb));
                tries++;
            end
        end
        drain0(1'b1);

        // longer random run: random operands, bubbles and stalls
        for (int i = 0; i < 400; i++) begin
            ra = rand_any();
            rb = rand_any();
            drive0(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), ra, rb, ref_mul(ra, rb));
        end
        drain0(1'b1);
        sb_on = 1'b0;

        // reset mid-flight: the third pair coincides with reset and is dropped
        drive0(1'b1, 1'b1, 32'h3FC00000, 32'h3FC00000, 36'd0);
        drive0(1'b1, 1'b1, 32'h40000000, 32'h40000000, 36'd0);
        @(negedge clk);
        if0.dataa = 32'h40400000; if0.datab = 32'h40400000; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; if0.in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("rstmid_valid", if0.out_valid, 0);
            check("rstmid_result", {if0.flags, if0.result}, 0);
        end
        lat0("after_rst", 32'h40000000, 32'h40400000, {4'h0, 32'h40C00000});

        // truncating instance
        lat1("trunc_tie", 32'h3F800001, 32'h3FC00000, {4'h1, 32'h3FC00001});
        lat1("trunc_nocarry", 32'h3F800001, 32'h3FFFFFFE, {4'h1, 32'h3FFFFFFF});

        // half precision instance
        lat2("half_1x2", 16'h3C00, 16'h4000, {4'h0, 16'h4000});
        lat2("half_ovf", 16'h7BFF, 16'h4000, {4'h5, 16'h7C00});

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/fpmult_pipe.md
# fpmult_pipe

Parametrised, fully pipelined IEEE-754-style floating-point multiplier for the DSP datapath. It accepts one operand pair per enabled cycle and returns a product with fixed latency. Compared with the earlier single-precision step-sequenced multiplier, it adds:
- configurable exponent and mantissa widths;
- round-to-nearest-even;
- correct infinity and NaN handling;
- exception flags;
- a clock-enable for stalling behind downstream consumers.

## Interface
Parameters:
- EXP_W, 8, exponent field width (≥3).
- MAN_W, 23, stored mantissa (fraction) width (≥2). Word width W = 1+EXP_W+MAN_W.
- ROUND_NE, 1: 1 = round-to-nearest-even, 0 = truncate toward zero.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ce  in  1  pipeline enable. When low, every stage register holds.
- in_valid  in  1  dataa/datab carry an operand pair this cycle. Sampled only when ce=1.
- dataa  in  W  operand A: {sign, exp, frac}.
- datab  in  W  operand B.
- out_valid  out  1  result/flags hold a product.
- result  out  W  product.
- flags  out  4  {invalid, overflow, underflow, inexact}. Qualified by out_valid.

## Operation
- Bias B = 2^(EXP_W-1)-1. EMAX = 2^EXP_W-1 (all-ones exponent field).
- Operand classes:
  - zero: exp=0. Denormal inputs are flushed to zero.
  - inf: exp=EMAX and frac=0.
  - NaN: exp=EMAX and frac≠0.
  - normal: otherwise.
- Four stages, each advancing only when ce=1. A valid bit travels with each stage.
- S1 (unpack):
  - Register sign = signA^signB.
  - Register the biased exponents.
  - Register the mantissas with the hidden 1 prepended, giving MAN_W+1 bits each.
  - Register the class bits.
- S2 (multiply):
  - Form the full 2·MAN_W+2-bit mantissa product P.
  - Compute signed exponent E = expA+expB−B in EXP_W+2 bits. It must not wrap.
- S3 (normalise/round):
  - If P MSB=1: take the mantissa from P[2MAN_W:MAN_W+1] and set E=E+1.
  - Otherwise take the mantissa from P[2MAN_W−1:MAN_W].
  - Guard = the next lower bit. Sticky = OR of all remaining bits.
  - When ROUND_NE=1, increment if guard & (sticky | mantissa LSB).
  - inexact = guard|sticky.
- S4 (renormalise/except):
  - If rounding carries out of the mantissa, set the fraction to 0 and E=E+1.
  - Result priority (highest first):
    1. Any NaN input, or inf×zero: canonical NaN {0, EMAX, 1 followed by zeros}, invalid=1.
    2. Any inf input: {sign, EMAX, 0}.
    3. Any zero input: {sign, 0, 0}, all flags 0.
    4. E ≥ EMAX: {sign, EMAX, 0}, overflow=1, inexact=1.
    5. E ≤ 0: {sign, 0, 0}. The product is flushed (no denormal output). underflow=1, inexact=1.
    6. Otherwise: {sign, E[EXP_W-1:0], rounded fraction} with the inexact flag from S3.
- Flags in the special-case rows (1–3) are 0 except where listed.

## Timing
- Latency: exactly 4 enabled cycles. A pair accepted on the edge with ce=1, in_valid=1 appears on out_valid/result after the 4th enabled edge, counting the accepting edge as the 1st.
- Throughput: one product per enabled cycle. Back-to-back inputs produce back-to-back outputs in order.
- ce=0 freezes all stage registers and outputs, including out_valid. Data is never lost or duplicated across a stall of any length.
- in_valid=0 inserts a bubble. out_valid=0 for that slot, and result/flags may hold stale data.
- reset:
  - All valid bits clear, out_valid=0, result=0, flags=0 on the next edge, regardless of ce.
  - In-flight operations are discarded.
  - The first input accepted after reset deasserts emerges 4 enabled cycles later.
- reset and ce=1 with in_valid=1 in the same cycle: reset wins and the input is dropped.

## Test plan
- Basic latency: default params, ce=1; 0x40000000×0x40400000 (2×3) on cycle 0 -> result 0x40C00000, flags 0, out_valid high only on cycle 4.
- Normalise and round (ROUND_NE=1):
  - 0x3FC00000×0x3FC00000 -> 0x40100000, inexact=0.
  - Tie case 0x3F800001×0x3FC00000 -> 0x3FC00002, inexact=1.
  - Same tie case with ROUND_NE=0 -> 0x3FC00001.
- Exceptions:
  - 0x7F000000×0x7F000000 -> 0x7F800000, overflow=1.
  - 0x00800000×0x80800000 -> 0x80000000, underflow=1.
  - 0x7F800000×0x00000000 -> 0x7FC00000, invalid=1.
  - 0xFF800000×0x40000000 -> 0xFF800000, flags 0.
- Streaming with stalls: 8 random normal pairs on consecutive cycles with ce toggled pseudo-randomly -> 8 outputs in order, each matching a reference model, with no duplicates during ce=0.
- Reset mid-flight: issue 3 pairs, assert reset on cycle 2 -> out_valid stays 0 and result=0 until a new pair is issued. The new pair returns exactly 4 cycles later.
- Alternate width: EXP_W=5, MAN_W=10 (half precision); 0x3C00×0x4000 (1×2) -> 0x4000; 0x7BFF×0x4000 -> 0x7C00 with overflow=1.
